// File: rtl/cic_decim_sequencer.sv
// rtl/cic_decim_sequencer.sv - CIC decimator control: integrator enable/clear, comb strobe, warm-up discard, output register
// Keeps the whole filter in the clk domain by replacing the divided clock with a single-cycle comb strobe.
module cic_decim_sequencer #(
    parameter int STAGES     = 2,
    parameter int CTR_WIDTH  = 4,
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cfg_load,
    input  logic [CTR_WIDTH-1:0]  ratio_m1,
    output logic                  integ_en,
    output logic                  integ_clr,
    output logic                  comb_en,
    input  logic [DATA_WIDTH-1:0] comb_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic [1:0]            state
);

    localparam int WARM_W = $clog2(STAGES + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(STAGES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        WARMUP = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CTR_WIDTH-1:0]  r_ratio;
    logic [CTR_WIDTH-1:0]  r_phase;
    logic [WARM_W-1:0]     r_warm;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  w_active;
    logic                  w_strobe;
    logic                  w_capture;
    logic                  w_handshake;

    assign w_active    = (r_state == WARMUP) || (r_state == RUN);
    assign w_strobe    = w_active && (r_phase == r_ratio);
    assign w_capture   = (r_state == RUN) && w_strobe;
    assign w_handshake = r_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // enable low takes priority over a restart request
    always_comb begin
        w_next    = r_state;
        integ_en  = 1'b0;
        integ_clr = 1'b0;
        comb_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_next = FLUSH;
            end
            FLUSH: begin
                integ_clr = 1'b1;
                w_next    = enable ? WARMUP : IDLE;
            end
            WARMUP: begin
                integ_en = 1'b1;
                comb_en  = w_strobe;
                if (!enable)                             w_next = IDLE;
                else if (cfg_load)                       w_next = FLUSH;
                else if (w_strobe && r_warm == WARM_LAST) w_next = RUN;
            end
            RUN: begin
                integ_en = 1'b1;
                comb_en  = w_strobe;
                if (!enable)       w_next = IDLE;
                else if (cfg_load) w_next = FLUSH;
            end
            default: w_next = IDLE;
        endcase
    end

    // R=1 would strobe every cycle with no integration; coerce to R=2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ratio <= CTR_WIDTH'(1);
        end else if (cfg_load) begin
            r_ratio <= (ratio_m1 == '0) ? CTR_WIDTH'(1) : ratio_m1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_warm  <= '0;
        end else if (!w_active) begin
            r_phase <= '0;
            r_warm  <= '0;
        end else if (w_strobe) begin
            r_phase <= '0;
            if (r_state == WARMUP) r_warm <= r_warm + 1'b1;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    // a capture coinciding with a handshake replaces the consumed sample cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_data  <= comb_data;
                r_valid <= 1'b1;
                if (r_valid && !out_ready) r_overrun <= 1'b1;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end
            if (cfg_load && r_state == IDLE) r_overrun <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;
    assign state     = r_state;

endmodule

// File: tb/tb_cic_decim_sequencer.sv
// tb/tb_cic_decim_sequencer.sv - directed scoreboard bench for cic_decim_sequencer
module tb_cic_decim_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       cfg_load;
    logic [3:0] ratio_m1;
    logic       integ_en;
    logic       integ_clr;
    logic       comb_en;
    logic [8:0] comb_data;
    logic [8:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic [1:0] state;

    logic [15:0] cyc;
    int          checks   = 0;
    int          failures = 0;
    int          exp_q[$];

    assign comb_data = cyc[8:0];

    cic_decim_sequencer #(.STAGES(2), .CTR_WIDTH(4), .DATA_WIDTH(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cfg_load  (cfg_load),
        .ratio_m1  (ratio_m1),
        .integ_en  (integ_en),
        .integ_clr (integ_clr),
        .comb_en   (comb_en),
        .comb_data (comb_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 16'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_ratio(input logic [3:0] r);
        cfg_load = 1'b1;
        ratio_m1 = r;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic begin_run();
        cyc    = 16'd0;
        enable = 1'b1;
    endtask

    // monitor: every accepted sample must match the oldest expected value
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected got=%0d required=none", out_data);
            end else begin
                chk("sb_data", int'(out_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; ratio_m1 = 4'd0;
        out_ready = 1'b1; cyc = 16'd0;
        idle(3);
        chk("rst_state", state, 0);
        chk("rst_outs", {integ_en, integ_clr, comb_en, out_valid, overrun}, 0);
        chk("rst_data", out_data, 0);
        rst_n = 1'b1;
        idle(2);

        // reset mid-RUN with R=6, then default R=2 must be restored
        load_ratio(4'd5);
        begin_run();
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 7 || c == 13) chk("t1_r6_strobe", comb_en, 1);
            if (c == 14) chk("t1_run", state, 3);
        end
        rst_n = 1'b0;
        #1;
        chk("t1_rst_state", state, 0);
        chk("t1_rst_outs", {integ_en, integ_clr, comb_en, out_valid, overrun}, 0);
        enable = 1'b0;
        idle(2);
        rst_n = 1'b1;
        tick();
        chk("t1_idle", state, 0);
        begin_run();
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("t1_comb_en", comb_en, int'(c >= 3 && c % 2 == 1));
            if (c == 7 || c == 9) exp_q.push_back(c);
            if (c == 10) enable = 1'b0;
        end
        idle(3);

        // R=4 with a ready consumer
        load_ratio(4'd3);
        begin_run();
        for (int c = 1; c <= 21; c++) begin
            tick();
            chk("t2_comb_en", comb_en, int'(c >= 5 && c <= 20 && (c - 1) % 4 == 0));
            chk("t2_integ_clr", integ_clr, int'(c == 1));
            chk("t2_integ_en", integ_en, int'(c >= 2 && c <= 20));
            if (c == 13 || c == 17) exp_q.push_back(c);
            if (c == 2) chk("t2_warmup", state, 2);
            if (c == 10) chk("t2_run", state, 3);
            if (c == 14) begin chk("t2_valid14", out_valid, 1); chk("t2_data14", out_data, 13); end
            if (c == 15) chk("t2_valid15", out_valid, 0);
            if (c == 20) enable = 1'b0;
        end
        idle(3);

        // stalled consumer: 13 is overwritten by 17
        load_ratio(4'd3);
        out_ready = 1'b0;
        begin_run();
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 17) exp_q.push_back(c);
            if (c == 14) begin chk("t3a_data14", out_data, 13); chk("t3a_ovr14", overrun, 0); end
            if (c == 17) chk("t3a_ovr17", overrun, 0);
            if (c == 18) begin
                chk("t3a_data18", out_data, 17);
                chk("t3a_valid18", out_valid, 1);
                chk("t3a_ovr18", overrun, 1);
            end
            if (c == 20) enable = 1'b0;
        end
        out_ready = 1'b1;
        idle(2);
        chk("t3a_valid_idle", out_valid, 0);
        chk("t3a_ovr_sticky", overrun, 1);
        load_ratio(4'd3);
        chk("t3a_ovr_clear", overrun, 0);

        // handshake in the capture cycle: no overrun
        out_ready = 1'b0;
        begin_run();
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 13 || c == 17) exp_q.push_back(c);
            if (c == 17) out_ready = 1'b1;
            if (c == 18) begin
                out_ready = 1'b0;
                chk("t3b_valid18", out_valid, 1);
                chk("t3b_data18", out_data, 17);
                chk("t3b_ovr18", overrun, 0);
            end
            if (c == 20) enable = 1'b0;
        end
        out_ready = 1'b1;
        idle(3);

        // reload R=8 during RUN
        load_ratio(4'd3);
        begin_run();
        for (int c = 1; c <= 41; c++) begin
            tick();
            if (c <= 15) chk("t4_comb_en_r4", comb_en, int'(c >= 5 && (c - 1) % 4 == 0));
            else         chk("t4_comb_en_r8", comb_en, int'(c >= 24 && (c - 24) % 8 == 0));
            if (c == 13 || c == 40) exp_q.push_back(c);
            if (c == 15) begin cfg_load = 1'b1; ratio_m1 = 4'd7; end
            if (c == 16) begin
                cfg_load = 1'b0;
                chk("t4_flush", state, 1);
                chk("t4_clr", integ_clr, 1);
            end
            if (c == 17) chk("t4_warmup", state, 2);
            if (c == 33) chk("t4_run", state, 3);
            if (c == 41) begin chk("t4_data41", out_data, 40); enable = 1'b0; end
        end
        idle(3);

        // ratio_m1=0 coerced to R=2
        load_ratio(4'd0);
        begin_run();
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("t5_comb_en_r2", comb_en, int'(c >= 3 && c % 2 == 1));
            if (c == 7 || c == 9 || c == 11) exp_q.push_back(c);
            if (c == 12) enable = 1'b0;
        end
        idle(3);

        // maximum ratio R=16
        load_ratio(4'd15);
        begin_run();
        for (int c = 1; c <= 50; c++) begin
            tick();
            chk("t5_comb_en_r16", comb_en, int'(c >= 17 && (c - 17) % 16 == 0));
            if (c == 49) exp_q.push_back(c);
            if (c == 34) chk("t5_run", state, 3);
            if (c == 50) enable = 1'b0;
        end
        idle(3);

        // enable dropped during WARMUP with a pending sample
        load_ratio(4'd3);
        out_ready = 1'b0;
        begin_run();
        for (int c = 1; c <= 38; c++) begin
            tick();
            if (c == 13 || c == 37) exp_q.push_back(c);
            if (c == 14) cfg_load = 1'b1;
            if (c == 15) begin
                cfg_load = 1'b0;
                chk("t6_flush", state, 1);
                chk("t6_valid_flush", out_valid, 1);
            end
            if (c == 19) begin chk("t6_strobe19", comb_en, 1); chk("t6_warmup", state, 2); end
            if (c == 20) enable = 1'b0;
            if (c == 21) begin
                chk("t6_idle", state, 0);
                chk("t6_valid_idle", out_valid, 1);
                chk("t6_integ_en_idle", integ_en, 0);
            end
            if (c == 23) chk("t6_no_strobe", comb_en, 0);
            if (c == 24) enable = 1'b1;
            if (c == 25) chk("t6_reflush", state, 1);
            if (c == 29 || c == 33) chk("t6_rewarm_strobe", comb_en, 1);
            if (c == 34) chk("t6_rerun", state, 3);
            if (c == 35) begin chk("t6_data_hold", out_data, 13); chk("t6_valid_hold", out_valid, 1); end
            if (c == 36) out_ready = 1'b1;
            if (c == 38) begin
                chk("t6_data38", out_data, 37);
                chk("t6_ovr", overrun, 0);
                enable = 1'b0;
            end
        end
        idle(3);

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
